digit_serial_alu: RTL and testbench

Parametrised digit-serial arithmetic unit. It processes one DIGIT_W-bit slice of two WORD_W-bit operands per clock through an internal digit ALU, and carries or shift bits between slices. It sits between the register file and writeback, where a full-width ALU is too large. Compared with the fixed 32-bit/nibble loop, it adds:
- configurable word and digit width
- a start/done handshake with operand latching
- subtraction, logic ops and left shift
- carry and zero flags
- asynchronous reset

---
 rtl/digit_serial_alu.sv | 166 ++++++++++++++++
 tb/tb_digit_serial_alu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: one DIGIT_W slice per clock, done pulses NDIGITS+1 edges after accept.
// No backpressure: start is taken only while busy=0 (IDLE or the DONE cycle) and is dropped otherwise.
module digit_serial_alu #(
  parameter int WORD_W  = 32,
  parameter int DIGIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        cmd,
  input  logic [WORD_W-1:0] word1,
  input  logic [WORD_W-1:0] word2,
  input  logic              shift_in,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic              carry_out,
  output logic              zero
);

  localparam int NDIGITS = WORD_W / DIGIT_W;
  localparam int IDX_W   = $clog2(NDIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

  typedef logic [NDIGITS-1:0][DIGIT_W-1:0] word_t;

  typedef enum logic [2:0] {
    CMD_ADD   = 3'd0,
    CMD_SUB   = 3'd1,
    CMD_AND   = 3'd2,
    CMD_OR    = 3'd3,
    CMD_XOR   = 3'd4,
    CMD_LSHFT = 3'd5,
    CMD_RSHFT = 3'd6,
    CMD_MOVE  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e               state_q;
  cmd_e                 cmd_q;
  cmd_e                 cmd_in;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  word_t                a_q;
  word_t                b_q;
  word_t                result_q;
  word_t                result_d;
  logic                 carry_q;
  logic                 carry_d;
  logic                 carry_init;
  logic                 carry_out_q;
  logic                 zero_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 last_dig;
  logic [DIGIT_W-1:0]   a_dig;
  logic [DIGIT_W-1:0]   b_dig;
  logic [DIGIT_W-1:0]   dig_d;

  assign cmd_in = cmd_e'(cmd);
  assign a_dig  = a_q[idx_q];
  assign b_dig  = b_q[idx_q];

  // RSHFT walks MSB to LSB, everything else LSB to MSB; terminal digit is tested before stepping.
  assign last_dig = (cmd_q == CMD_RSHFT) ? (idx_q == '0) : (idx_q == IDX_LAST);
  assign idx_d    = (cmd_q == CMD_RSHFT) ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));

  always_comb begin
    carry_init = 1'b0;
    case (cmd_in)
      CMD_SUB:   carry_init = 1'b1;
      CMD_LSHFT: carry_init = shift_in;
      CMD_RSHFT: carry_init = shift_in;
      default:   carry_init = 1'b0;
    endcase
  end

  always_comb begin
    dig_d   = '0;
    carry_d = carry_q;
    case (cmd_q)
      CMD_ADD:   {carry_d, dig_d} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_W{1'b0}}, carry_q};
      CMD_SUB:   {carry_d, dig_d} = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT_W{1'b0}}, carry_q};
      CMD_AND:   dig_d = a_dig & b_dig;
      CMD_OR:    dig_d = a_dig | b_dig;
      CMD_XOR:   dig_d = a_dig ^ b_dig;
      CMD_LSHFT: begin
        dig_d   = {a_dig[DIGIT_W-2:0], carry_q};
        carry_d = a_dig[DIGIT_W-1];
      end
      CMD_RSHFT: begin
        dig_d   = {carry_q, a_dig[DIGIT_W-1:1]};
        carry_d = a_dig[0];
      end
      CMD_MOVE:  dig_d = a_dig;
      default:   dig_d = '0;
    endcase
  end

  always_comb begin
    result_d        = result_q;
    result_d[idx_q] = dig_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= CMD_ADD;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          if (last_dig) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            carry_out_q <= carry_d;
            zero_q      <= (result_d == '0);
          end else begin
            idx_q <= idx_d;
          end
        end
        default: begin
          // IDLE and DONE both accept; accepting in DONE gives back-to-back ops.
          done_q <= 1'b0;
          if (start) begin
            a_q         <= word1;
            b_q         <= word2;
            cmd_q       <= cmd_in;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            idx_q       <= (cmd_in == CMD_RSHFT) ? IDX_LAST : '0;
            carry_q     <= carry_init;
            busy_q      <= 1'b1;
            state_q     <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_digit_serial_alu.sv
// Directed-vector bench for digit_serial_alu: 32/4 default instance and a 16/8 instance.
module tb_digit_serial_alu;

  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_AND = 3'd2, C_OR = 3'd3;
  localparam logic [2:0] C_XOR = 3'd4, C_LSH = 3'd5, C_RSH = 3'd6, C_MOV = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [2:0]  cmd;
  logic [31:0] word1, word2;
  logic        shift_in;
  logic        busy_a, done_a, carry_a, zero_a;
  logic [31:0] result_a;
  logic        busy_b, done_b, carry_b, zero_b;
  logic [15:0] result_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_serial_alu #(.WORD_W(32), .DIGIT_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cmd(cmd), .word1(word1), .word2(word2),
    .shift_in(shift_in), .busy(busy_a), .done(done_a), .result(result_a),
    .carry_out(carry_a), .zero(zero_a)
  );

  digit_serial_alu #(.WORD_W(16), .DIGIT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cmd(cmd), .word1(word1[15:0]), .word2(word2[15:0]),
    .shift_in(shift_in), .busy(busy_b), .done(done_b), .result(result_b),
    .carry_out(carry_b), .zero(zero_b)
  );

  // Issues one op and waits for done; lat counts edges from the accept edge (inclusive) to done.
  task automatic run_op(input bit which, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic si, output int lat,
                        output int busy_cyc, output logic [31:0] acc_res, output logic [1:0] acc_fl);
    @(negedge clk);
    cmd = c; word1 = a; word2 = b; shift_in = si;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    lat = 1;
    busy_cyc = 0;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    acc_res = which ? {16'h0, result_b} : result_a;
    acc_fl  = which ? {carry_b, zero_b} : {carry_a, zero_a};
    while (!(which ? done_b : done_a) && lat < 40) begin
      if (which ? busy_b : busy_a) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; cmd = C_ADD;
    word1 = '0; word2 = '0; shift_in = 1'b0;
    #12;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_a); end
    total++; if (result_a !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result_a); end
    total++; if ({carry_a, zero_a} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {carry_a, zero_a}); end
    total++; if ({busy_b, done_b, result_b} !== 18'h0) begin bad++; $display("FAIL reset_b got=%h want=0", {busy_b, done_b, result_b}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, bc; logic [31:0] ar; logic [1:0] af;
    run_op(1'b0, C_ADD, 32'hefffffff, 32'h00000001, 1'b0, lat, bc, ar, af);
    total++; if (result_a !== 32'hf0000000) begin bad++; $display("FAIL add_result got=%h want=f0000000", result_a); end
    total++; if ({carry_a, zero_a} !== 2'b00) begin bad++; $display("FAIL add_flags got=%b want=00", {carry_a, zero_a}); end
    total++; if (lat !== 9) begin bad++; $display("FAIL add_latency got=%0d want=9", lat); end
    total++; if (bc !== 8) begin bad++; $display("FAIL add_busy_cycles got=%0d want=8", bc); end
    @(negedge clk);
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL add_done_width got=%b want=0", done_a); end
  endtask

  task automatic test_add_sub();
    int lat, bc; logic [31:0] ar; logic [1:0] af;
    run_op(1'b0, C_ADD, 32'hffffffff, 32'h00000001, 1'b0, lat, bc, ar, af);
    total++; if (result_a !== 32'h0) begin bad++; $display("FAIL ovf_result got=%h want=0", result_a); end
    total++; if ({carry_a, zero_a} !== 2'b11) begin bad++; $display("FAIL ovf_flags got=%b want=11", {carry_a, zero_a}); end
    run_op(1'b0, C_SUB, 32'h00001000, 32'h00000001, 1'b0, lat, bc, ar, af);
    total++; if ({ar, af} !== 34'h0) begin bad++; $display("FAIL accept_clear got=%h/%b want=0/00", ar, af); end
    total++; if (result_a !== 32'h00000fff) begin bad++; $display("FAIL sub_result got=%h want=00000fff", result_a); end
    total++; if ({carry_a, zero_a} !== 2'b10) begin bad++; $display("FAIL sub_flags got=%b want=10", {carry_a, zero_a}); end
    run_op(1'b0, C_SUB, 32'h0, 32'h00000001, 1'b0, lat, bc, ar, af);
    total++; if (result_a !== 32'hffffffff) begin bad++; $display("FAIL sub_borrow_result got=%h want=ffffffff", result_a); end
    total++; if ({carry_a, zero_a} !== 2'b00) begin bad++; $display("FAIL sub_borrow_flags got=%b want=00", {carry_a, zero_a}); end
  endtask

  task automatic test_shift_logic();
    int lat, bc; logic [31:0] ar; logic [1:0] af;
    run_op(1'b0, C_RSH, 32'h06000000, 32'h12345678, 1'b0, lat, bc, ar, af);
    total++; if ({result_a, carry_a} !== {32'h03000000, 1'b0}) begin bad++; $display("FAIL rshft got=%h/%b want=03000000/0", result_a, carry_a); end
    run_op(1'b0, C_LSH, 32'h80000001, 32'h0, 1'b1, lat, bc, ar, af);
    total++; if ({result_a, carry_a} !== {32'h00000003, 1'b1}) begin bad++; $display("FAIL lshft got=%h/%b want=00000003/1", result_a, carry_a); end
    run_op(1'b0, C_XOR, 32'hf0f0f0f0, 32'hffffffff, 1'b1, lat, bc, ar, af);
    total++; if ({result_a, carry_a} !== {32'h0f0f0f0f, 1'b0}) begin bad++; $display("FAIL xor got=%h/%b want=0f0f0f0f/0", result_a, carry_a); end
    run_op(1'b0, C_AND, 32'h12345678, 32'h0f0f0f0f, 1'b0, lat, bc, ar, af);
    total++; if (result_a !== 32'h02040608) begin bad++; $display("FAIL and got=%h want=02040608", result_a); end
    run_op(1'b0, C_AND, 32'hf0f0f0f0, 32'h0f0f0f0f, 1'b0, lat, bc, ar, af);
    total++; if ({result_a, carry_a, zero_a} !== {32'h0, 2'b01}) begin bad++; $display("FAIL and_zero got=%h/%b%b want=0/01", result_a, carry_a, zero_a); end
    run_op(1'b0, C_OR, 32'h12340000, 32'h00005678, 1'b0, lat, bc, ar, af);
    total++; if (result_a !== 32'h12345678) begin bad++; $display("FAIL or got=%h want=12345678", result_a); end
    run_op(1'b0, C_MOV, 32'hdeadbeef, 32'h12345678, 1'b1, lat, bc, ar, af);
    total++; if ({result_a, carry_a} !== {32'hdeadbeef, 1'b0}) begin bad++; $display("FAIL move got=%h/%b want=deadbeef/0", result_a, carry_a); end
  endtask

  task automatic test_back_to_back();
    int prev = -1;
    int pulses = 0;
    int k = 0;
    @(negedge clk);
    cmd = C_ADD; word1 = 32'h1; word2 = 32'h1; shift_in = 1'b0; start_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) begin
        pulses++;
        if (prev < 0) begin
          total++; if (i !== 8) begin bad++; $display("FAIL b2b_first_done got=%0d want=8", i); end
        end else begin
          total++; if (i - prev !== 9) begin bad++; $display("FAIL b2b_gap got=%0d want=9", i - prev); end
        end
        total++; if (result_a !== 32'h2) begin bad++; $display("FAIL b2b_result got=%h want=2", result_a); end
        prev = i;
      end
    end
    total++; if (pulses !== 4) begin bad++; $display("FAIL b2b_pulses got=%0d want=4", pulses); end
    start_a = 1'b0;
    while ((busy_a || done_a) && k < 30) begin
      @(negedge clk);
      k++;
    end
    total++; if (k >= 30) begin bad++; $display("FAIL b2b_drain got=%0d want<30", k); end
  endtask

  task automatic test_ignore_start();
    int k = 0;
    int bc = 0;
    @(negedge clk);
    cmd = C_ADD; word1 = 32'h00000100; word2 = 32'h00000011; shift_in = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    cmd = C_SUB; word1 = 32'hffffffff; word2 = 32'hffffffff; shift_in = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (!done_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++; if (k !== 6) begin bad++; $display("FAIL ign_done_time got=%0d want=6", k); end
    total++; if ({result_a, carry_a, zero_a} !== {32'h00000111, 2'b00}) begin bad++; $display("FAIL ign_result got=%h/%b%b want=00000111/00", result_a, carry_a, zero_a); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy_a) bc++;
    end
    total++; if (bc !== 0) begin bad++; $display("FAIL ign_not_queued got=%0d want=0", bc); end
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic [31:0] ar; logic [1:0] af;
    int dn = 0;
    @(negedge clk);
    cmd = C_ADD; word1 = 32'h12345678; word2 = 32'h11111111; shift_in = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({busy_a, result_a} !== {1'b1, 32'h00000789}) begin bad++; $display("FAIL mid_partial got=%b/%h want=1/00000789", busy_a, result_a); end
    #2 rst = 1'b1;
    #1;
    total++; if ({busy_a, done_a, carry_a, zero_a} !== 4'b0000) begin bad++; $display("FAIL mid_rst_ctrl got=%b want=0000", {busy_a, done_a, carry_a, zero_a}); end
    total++; if (result_a !== 32'h0) begin bad++; $display("FAIL mid_rst_result got=%h want=0", result_a); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_a || busy_a) dn++;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", dn); end
    run_op(1'b0, C_ADD, 32'h00000fff, 32'h00000001, 1'b0, lat, bc, ar, af);
    total++; if ({result_a, carry_a, zero_a} !== {32'h00001000, 2'b00}) begin bad++; $display("FAIL mid_after_add got=%h/%b%b want=00001000/00", result_a, carry_a, zero_a); end
  endtask

  task automatic test_param();
    int lat, bc; logic [31:0] ar; logic [1:0] af;
    run_op(1'b1, C_ADD, 32'h000000ff, 32'h00000001, 1'b0, lat, bc, ar, af);
    total++; if ({result_b, carry_b, zero_b} !== {16'h0100, 2'b00}) begin bad++; $display("FAIL p16_add got=%h/%b%b want=0100/00", result_b, carry_b, zero_b); end
    total++; if (lat !== 3) begin bad++; $display("FAIL p16_latency got=%0d want=3", lat); end
    total++; if (bc !== 2) begin bad++; $display("FAIL p16_busy got=%0d want=2", bc); end
    run_op(1'b1, C_RSH, 32'h00008001, 32'h0, 1'b1, lat, bc, ar, af);
    total++; if ({result_b, carry_b} !== {16'hc000, 1'b1}) begin bad++; $display("FAIL p16_rshft got=%h/%b want=c000/1", result_b, carry_b); end
    run_op(1'b1, C_SUB, 32'h0, 32'h0, 1'b0, lat, bc, ar, af);
    total++; if ({result_b, carry_b, zero_b} !== {16'h0000, 2'b11}) begin bad++; $display("FAIL p16_sub got=%h/%b%b want=0000/11", result_b, carry_b, zero_b); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_add_sub();
    test_shift_logic();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
